// File: rtl/key_schedule_gen.sv
// AES key expansion (FIPS-197): streams w[0..NW-1] one word per handshake.
// The NK-word history holds the key during the key phase, then the sliding window w[i-NK..i-1].
module key_schedule_gen #(
  parameter int NK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [32*NK-1:0] i_key,
  input  logic             i_word_ready,
  output logic             o_word_valid,
  output logic [31:0]      o_word,
  output logic [5:0]       o_word_idx,
  output logic             o_busy,
  output logic             o_done
);
  localparam int NR        = NK + 6;
  localparam int NW        = 4 * (NR + 1);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(NK);
  localparam logic [PW-1:0] PH_HALF = PW'(NK / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(NK - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Byte 00 sits in the top 8 bits of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [NK-1:0][31:0]          hist;
  logic [7:0]                   rcon;
  logic [PW-1:0]                phase;
  logic [NUM_LANES-1:0][7:0]    sub_in, sub_out;
  logic [31:0]                  prev, temp, new_word, key_word;
  logic [5:0]                   nidx;
  logic                         xfer, last;

  assign xfer = o_word_valid & i_word_ready;
  assign last = (o_word_idx == 6'(NW - 1));
  assign nidx = o_word_idx + 6'd1;

  // hist[0] is the newest word, hist[NK-1] the oldest.
  assign prev   = hist[0];
  assign sub_in = (phase == '0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sub_out[g] = sbox(sub_in[g]);
  end

  always_comb begin
    temp = prev;
    if (phase == '0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && phase == PH_HALF)
      temp = sub_out;
  end

  assign new_word = hist[NK-1] ^ temp;

  always_comb begin
    key_word = '0;
    for (int k = 0; k < NK; k++)
      if (nidx == 6'(k)) key_word = hist[NK-1-k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (xfer && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_word_valid = (state == RUN);
    o_busy       = (state == RUN);
    o_done       = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist       <= '0;
      rcon       <= '0;
      phase      <= '0;
      o_word     <= '0;
      o_word_idx <= '0;
    end else if (state == IDLE && i_start) begin
      hist       <= i_key;
      rcon       <= 8'h01;
      phase      <= PW'(1);
      o_word     <= i_key[32*NK-1 -: 32];
      o_word_idx <= '0;
    end else if (xfer && !last) begin
      o_word_idx <= nidx;
      phase      <= (phase == PH_LAST) ? '0 : phase + PW'(1);
      // Key words are replayed from the untouched history; generation slides the window.
      if (nidx < 6'(NK)) begin
        o_word <= key_word;
      end else begin
        o_word <= new_word;
        hist   <= {hist[NK-2:0], new_word};
        if (phase == '0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end
endmodule

// File: doc/key_schedule_gen.md
KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 SHALL have parameter NK, default 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256); NR = NK+6 rounds; total words NW = 4*(NR+1) = 44/52/60.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request to begin expansion of i_key.
REQ-005 SHALL have port i_key  input  32*NK  cipher key; bits [32*NK-1 -: 32] form w[0].
REQ-006 SHALL have port i_word_ready  input  1  consumer accepts o_word this cycle.
REQ-007 SHALL have port o_word_valid  output  1  o_word/o_word_idx hold a valid schedule word.
REQ-008 SHALL have port o_word  output  32  schedule word w[o_word_idx].
REQ-009 SHALL have port o_word_idx  output  6  index i of the presented word, 0..NW-1.
REQ-010 SHALL have port o_busy  output  1  expansion in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: i_start=1 latches i_key into an NK-word history buffer and moves to RUN; o_word_valid=1 with w[0], idx 0, on the next cycle.
REQ-014 RUN: o_busy=1, o_word_valid=1; a word is transferred on any cycle with o_word_valid=1 and i_word_ready=1.
REQ-015 On transfer, the next word (idx+1) SHALL be presented the following cycle; throughput one word per cycle under continuous ready.
REQ-016 While i_word_ready=0, o_word and o_word_idx SHALL hold stable; no internal state advances.
REQ-017 Words 0..NK-1 SHALL be the key words in order; for i >= NK, w[i] = w[i-NK] XOR temp, with temp = w[i-1].
REQ-018 If i mod NK = 0: temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/NK]; RotWord is a left rotate by one byte ([23:0],[31:24]).
REQ-019 If NK = 8 and i mod NK = 4: temp = SubWord(w[i-1]); no rotate, no Rcon.
REQ-020 SubWord SHALL apply the FIPS-197 S-box to each of the four bytes independently, combinationally.
REQ-021 Rcon[j] SHALL be {rc_j, 24'h0}, rc = 01,02,04,08,10,20,40,80,1B,36 for j = 1..10; generated by GF(2^8) doubling (xtime) or a table.
REQ-022 The history buffer SHALL shift in each transferred word; w[i-NK] is the oldest entry, w[i-1] the newest.
REQ-023 Transfer of idx NW-1 SHALL move RUN -> DONE; DONE asserts o_done=1, o_busy=0, o_word_valid=0 for exactly one cycle, then -> IDLE.
REQ-024 i_start SHALL be ignored in RUN and DONE; i_key is sampled only on the accepting IDLE cycle.
REQ-025 i_start in IDLE and i_rst in the same cycle: reset wins, no expansion starts.
REQ-026 o_word_idx SHALL not wrap; the sequence terminates at NW-1.

Reset
REQ-027 i_rst=1 at a clock edge SHALL force IDLE, o_word_valid=0, o_busy=0, o_done=0, o_word=0, o_word_idx=0 on the next cycle, from any state including mid-RUN.
REQ-028 After reset mid-RUN, no further words from the aborted expansion SHALL appear; a new i_start restarts at idx 0.

Verification
REQ-029 NK=4, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, ready held 1 -> w[4]=a0fafe17, w[43]=b6630ca6, 44 consecutive valid cycles, o_done one cycle after idx 43.
REQ-030 NK=6, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
REQ-031 NK=8, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e.
REQ-032 NK=4, random i_word_ready toggling -> identical word sequence to REQ-029, o_word stable whenever valid=1 and ready=0.
REQ-033 i_rst asserted at idx 20 -> valid/busy low next cycle, no o_done; subsequent i_start yields w[0] again.
REQ-034 i_start pulsed during RUN with a different i_key -> ignored; expansion completes with the original key's values.
